// File: rtl/alu_op_encoder_if.sv
// alu_op_encoder_if: op request and instr output handshakes.
// slave = encoder side, master = producer/consumer side.
interface alu_op_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_ctrl;
  logic [4:0]        op_rd;
  logic [4:0]        op_rs1;
  logic [4:0]        op_rs2;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_word;
  logic [ADDR_W-1:0] instr_addr;

  modport master (
    output op_valid, op_ctrl, op_rd,
    output op_rs1, op_rs2, instr_ready,
    input  op_ready, instr_valid,
    input  instr_word, instr_addr
  );

  modport slave (
    input  op_valid, op_ctrl, op_rd,
    input  op_rs1, op_rs2, instr_ready,
    output op_ready, instr_valid,
    output instr_word, instr_addr
  );
endinterface

// File: rtl/alu_op_encoder.sv
// alu_op_encoder: ALU op requests -> RV32I R-type words, FIFO-buffered.
// Ports: clk, rst_n (async low), restart, bus (slave), instr_count, err_illegal.
module alu_op_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  alu_op_encoder_if.slave    bus,
  output logic [15:0]        instr_count,
  output logic               err_illegal
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_icnt;
  logic              r_err;

  logic        w_full;
  logic        w_empty;
  logic        w_acc;
  logic        w_push;
  logic        w_pop;
  logic        w_legal;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_word;

  assign w_full  = (r_cnt == L_FULL);
  assign w_empty = (r_cnt == '0);

  always_comb begin
    w_legal = 1'b1;
    w_f7    = 7'b0000000;
    w_f3    = 3'b000;
    unique case (1'b1)
      (bus.op_ctrl == 3'b000): ;
      (bus.op_ctrl == 3'b001): w_f7 = 7'b0100000;
      (bus.op_ctrl == 3'b010): w_f3 = 3'b111;
      (bus.op_ctrl == 3'b011): w_f3 = 3'b110;
      default:                 w_legal = 1'b0;
    endcase
  end

  assign w_word = {w_f7, bus.op_rs2, bus.op_rs1,
                   w_f3, bus.op_rd, 7'b0110011};

  // Ready never looks at op_valid; a pop this cycle
  // does not open a slot until the next edge.
  assign bus.op_ready = rst_n && !w_full && !restart;

  assign w_acc  = bus.op_valid && bus.op_ready;
  assign w_push = w_acc && w_legal;
  assign w_pop  = !w_empty && bus.instr_ready;

  assign bus.instr_valid = !w_empty;
  assign bus.instr_word  = w_empty ? '0 : r_mem[r_rptr];
  assign bus.instr_addr  = r_addr;
  assign instr_count     = r_icnt;
  assign err_illegal     = r_err;

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_addr <= BASE_ADDR;
      r_icnt <= '0;
      r_err  <= 1'b0;
    end else if (restart) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_addr <= BASE_ADDR;
      r_icnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_acc && !w_legal) r_err <= 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= r_addr + ADDR_W'(4);
        if (r_icnt != 16'hFFFF) r_icnt <= r_icnt + 16'd1;
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

Buffered encoder that turns ALU operation requests into RV32I R-type instruction words. It is the inverse of the ALU control decode path: a test program loader or sequencer pushes operation requests in, and the block emits encoded words with sequential instruction-memory byte addresses. A small FIFO sits between the two sides, both of which use valid/ready handshakes.

## Interface
- DEPTH, 4: FIFO entries; a power of two, minimum 2.
- ADDR_W, 32: width of the instruction address.
- BASE_ADDR, 0: address of the first emitted word after reset or restart.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset. Asynchronous, active-low.
- restart  in  1  Synchronous clear of the FIFO, address, count and error flag.
- op_valid  in  1  An operation request is present.
- op_ready  out  1  The block accepts the request this cycle.
- op_ctrl  in  3  Operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100–111 illegal.
- op_rd, op_rs1, op_rs2  in  5 each  Register indices.
- instr_valid  out  1  An encoded word is available.
- instr_ready  in  1  The consumer takes the word.
- instr_word  out  32  Encoded instruction.
- instr_addr  out  ADDR_W  Byte address of instr_word.
- instr_count  out  16  Number of words emitted; saturates at 0xFFFF.
- err_illegal  out  1  Sticky flag: an illegal op_ctrl was accepted.

## Operation
- Encoding: word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - ADD: funct7 = 0000000, funct3 = 000.
  - SUB: funct7 = 0100000, funct3 = 000.
  - AND: funct7 = 0000000, funct3 = 111.
  - OR: funct7 = 0000000, funct3 = 110.
- Encoding is combinational on the inputs; the encoded word is written into the FIFO on the accept edge.
- Accept occurs when op_valid && op_ready.
  - A legal op is pushed into the FIFO.
  - An illegal op is consumed, nothing is pushed, and err_illegal is set.
- op_ready = rst_n && !full && !restart. There is no pass-through when full, even if a pop happens in the same cycle.
- instr_valid = !empty. instr_word is the FIFO head.
- Pop occurs when instr_valid && instr_ready. On each pop:
  - instr_addr increases by 4, modulo 2^ADDR_W (wraps to 0).
  - instr_count increments unless it is already 0xFFFF.
- A push and a pop in the same cycle (FIFO neither empty nor full) leave the occupancy unchanged.
- Restart takes priority over both handshakes in that cycle:
  - The FIFO is emptied.
  - instr_addr is set to BASE_ADDR.
  - instr_count and err_illegal are cleared.
  - A pop offered in that cycle does not advance the address or the count.
- Reset mid-operation: all queued words are discarded, with no partial emission.

## Timing
- Reset values:
  - instr_valid = 0, instr_addr = BASE_ADDR, instr_count = 0, err_illegal = 0.
  - instr_word = 0.
  - op_ready = 0 while rst_n is low; it rises with rst_n deassertion because the FIFO is empty.
- Latency: a word accepted at edge N is presented with instr_valid = 1 after edge N, when the FIFO was empty.
- err_illegal is visible after the accept edge of the illegal op.
- While instr_valid && !instr_ready, instr_word and instr_addr hold stable.
- op_ready depends only on registered state, rst_n and restart. It never depends on op_valid.
- Throughput is one word per cycle in each direction.
- A full FIFO drops op_ready for at least one cycle after a pop frees an entry. The full flag updates at the edge.

## Test plan
- Single-op encoding, each presented at instr_addr = BASE_ADDR:
  - ADD x3,x1,x2 → 0x002081B3.
  - SUB x5,x6,x7 → 0x407302B3.
  - AND x1,x2,x3 → 0x003170B3.
  - OR x4,x4,x4 → 0x00426233.
- Backpressure: hold instr_ready = 0 and push 5 ops with DEPTH = 4.
  - op_ready must fall after the 4th accept.
  - Release instr_ready: the words drain in order at addresses 0, 4, 8, 12; instr_count = 4. The 5th op is accepted afterwards.
- Illegal op: op_ctrl = 101 is accepted; no word is emitted and err_illegal = 1. A following ADD still encodes correctly, and the flag stays set until restart.
- Address wrap: ADDR_W = 4, BASE_ADDR = 12, two pops → addresses 12 then 0.
- Simultaneous events:
  - Restart in the same cycle as a push and a pop: the FIFO ends empty, the address equals BASE_ADDR, count = 0, and no push occurs.
  - Concurrent push and pop at occupancy 2: occupancy stays at 2.
- Asynchronous reset with 3 words queued:
  - instr_valid drops immediately, without waiting for a clock edge.
  - After release, instr_addr = BASE_ADDR, instr_count = 0, and no stale word appears.
